// File: rtl/audio_ser_tx.sv
// Stereo left-justified serial audio transmitter.
// A one-pair holding buffer feeds a 2*WIDTH-bit shift register, so the next
// pair can be accepted while the current frame is still being shifted out.
// The bit clock stops, and underrun pulses, when a frame ends with no pair waiting.
module audio_ser_tx #(
    parameter int WIDTH     = 24,
    parameter int BCLK_HALF = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_left,
    input  logic [WIDTH-1:0] in_right,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             busy,
    output logic             underrun
);

    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int BIT_W = $clog2(2 * WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_HALF - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * WIDTH - 1);
    localparam logic [BIT_W-1:0] LEFT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic               buf_full_q, buf_full_d;
    logic [WIDTH-1:0]   buf_l_q, buf_l_d;
    logic [WIDTH-1:0]   buf_r_q, buf_r_d;
    logic [2*WIDTH-1:0] shift_q, shift_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               sclk_q, sclk_d;
    logic               lrclk_q, lrclk_d;
    logic               sdata_q, sdata_d;
    logic               underrun_q, underrun_d;

    logic accept;
    logic fall;
    logic frame_end;
    logic load;

    assign accept    = in_valid && !buf_full_q;
    assign fall      = (state_q == RUN) && (div_cnt_q == DIV_LAST) && sclk_q;
    assign frame_end = fall && (bit_cnt_q == BIT_LAST);
    // A waiting pair starts a frame from IDLE, or chains directly at frame end.
    assign load      = buf_full_q && ((state_q == IDLE) || frame_end);

    // Next-state logic: buffer handshake, bit-clock divider, shifting and frame sequencing.
    always_comb begin
        state_d    = state_q;
        buf_full_d = buf_full_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        shift_d    = shift_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sclk_d     = sclk_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;

        if (accept) begin
            buf_full_d = 1'b1;
            buf_l_d    = in_left;
            buf_r_d    = in_right;
        end

        if (state_q == RUN) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                sclk_d    = !sclk_q;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end

        // Data and word select only move on the falling bit-clock edge.
        if (fall && !frame_end) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            shift_d   = shift_q << 1;
            sdata_d   = shift_q[2*WIDTH-2];
            lrclk_d   = lrclk_q || (bit_cnt_q == LEFT_LAST);
        end

        if (frame_end && !buf_full_q) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            sclk_d     = 1'b0;
            lrclk_d    = 1'b0;
            sdata_d    = 1'b0;
            underrun_d = 1'b1;
        end

        if (load) begin
            state_d    = RUN;
            buf_full_d = 1'b0;
            shift_d    = {buf_l_q, buf_r_q};
            div_cnt_d  = '0;
            bit_cnt_d  = '0;
            sclk_d     = 1'b0;
            lrclk_d    = 1'b0;
            sdata_d    = buf_l_q[WIDTH-1];
        end
    end

    // Control state and serial outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            buf_full_q <= 1'b0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_full_q <= buf_full_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
        end
    end

    // Sample storage; contents are qualified by buf_full_q and state, so no reset.
    always_ff @(posedge clk) begin
        buf_l_q <= buf_l_d;
        buf_r_q <= buf_r_d;
        shift_q <= shift_d;
    end

    assign in_ready = !buf_full_q;
    assign sclk     = sclk_q;
    assign lrclk    = lrclk_q;
    assign sdata    = sdata_q;
    assign busy     = (state_q == RUN);
    assign underrun = underrun_q;

endmodule

// File: tb/tb_audio_ser_tx.sv
// Directed bench for audio_ser_tx: default instance (24-bit, half-period 2)
// and a 16-bit, half-period 1 instance, each observed by a DAC capture model.
module tb_audio_ser_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [23:0] in_left, in_right;
    logic        in_valid = 1'b0;
    logic        in_ready, sclk, lrclk, sdata, busy, underrun;

    logic [15:0] in_left2, in_right2;
    logic        in_valid2 = 1'b0;
    logic        in_ready2, sclk2, lrclk2, sdata2, busy2, underrun2;

    audio_ser_tx dut (
        .clk(clk), .rst(rst), .in_left(in_left), .in_right(in_right),
        .in_valid(in_valid), .in_ready(in_ready), .sclk(sclk), .lrclk(lrclk),
        .sdata(sdata), .busy(busy), .underrun(underrun)
    );

    audio_ser_tx #(.WIDTH(16), .BCLK_HALF(1)) dut2 (
        .clk(clk), .rst(rst), .in_left(in_left2), .in_right(in_right2),
        .in_valid(in_valid2), .in_ready(in_ready2), .sclk(sclk2), .lrclk(lrclk2),
        .sdata(sdata2), .busy(busy2), .underrun(underrun2)
    );

    int n_chk = 0;
    int n_fail = 0;

    // DAC model for the default instance: shift sdata in on rising sclk.
    int cyc = 0, last_rise = -1, rmin = 999999, rmax = 0;
    int last_lr = -1, lmin = 999999, lmax = 0, ur_cnt = 0, nb = 0, lr_err = 0;
    logic ps = 1'b0, pl = 1'b0, wlr = 1'b0;
    logic [23:0] acc = '0;
    logic [24:0] words[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            nb = 0; ps = 1'b0; pl = 1'b0;
        end else begin
            if (underrun) ur_cnt++;
            if (sclk && !ps) begin
                if (last_rise >= 0) begin
                    if (cyc - last_rise < rmin) rmin = cyc - last_rise;
                    if (cyc - last_rise > rmax) rmax = cyc - last_rise;
                end
                last_rise = cyc;
                acc = {acc[22:0], sdata};
                if (nb == 0) wlr = lrclk;
                else if (lrclk !== wlr) lr_err++;
                nb++;
                if (nb == 24) begin
                    words.push_back({wlr, acc});
                    nb = 0;
                end
            end
            if (lrclk && !pl) begin
                if (last_lr >= 0) begin
                    if (cyc - last_lr < lmin) lmin = cyc - last_lr;
                    if (cyc - last_lr > lmax) lmax = cyc - last_lr;
                end
                last_lr = cyc;
            end
            ps = sclk;
            pl = lrclk;
        end
    end

    // DAC model for the 16-bit instance.
    int cyc2 = 0, last_rise2 = -1, rmin2 = 999999, rmax2 = 0, ur_cnt2 = 0, nb2 = 0, lr_err2 = 0;
    logic ps2 = 1'b0, wlr2 = 1'b0;
    logic [15:0] acc2 = '0;
    logic [16:0] words2[$];

    always @(posedge clk) begin
        #1;
        cyc2++;
        if (rst) begin
            nb2 = 0; ps2 = 1'b0;
        end else begin
            if (underrun2) ur_cnt2++;
            if (sclk2 && !ps2) begin
                if (last_rise2 >= 0) begin
                    if (cyc2 - last_rise2 < rmin2) rmin2 = cyc2 - last_rise2;
                    if (cyc2 - last_rise2 > rmax2) rmax2 = cyc2 - last_rise2;
                end
                last_rise2 = cyc2;
                acc2 = {acc2[14:0], sdata2};
                if (nb2 == 0) wlr2 = lrclk2;
                else if (lrclk2 !== wlr2) lr_err2++;
                nb2++;
                if (nb2 == 16) begin
                    words2.push_back({wlr2, acc2});
                    nb2 = 0;
                end
            end
            ps2 = sclk2;
        end
    end

    task automatic clear_stats();
        last_rise = -1; rmin = 999999; rmax = 0;
        last_lr = -1; lmin = 999999; lmax = 0;
        lr_err = 0;
        words.delete();
    endtask

    // Offer one pair and hold it until accepted; returns negedges spent waiting.
    task automatic send(input logic [23:0] l, input logic [23:0] r, output int waited);
        waited = 0;
        @(negedge clk);
        in_left = l; in_right = r; in_valid = 1'b1;
        while (!in_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send2(input logic [15:0] l, input logic [15:0] r);
        int w;
        w = 0;
        @(negedge clk);
        in_left2 = l; in_right2 = r; in_valid2 = 1'b1;
        while (!in_ready2 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
    endtask

    // Cycles until the next underrun pulse (bounded).
    task automatic wait_underrun(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!underrun && n < 3000);
    endtask

    task automatic test_reset();
        int w;
        n_chk++; if (sclk !== 1'b0 || lrclk !== 1'b0 || sdata !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got sclk=%b lrclk=%b sdata=%b expected 0 0 0", sclk, lrclk, sdata); end
        n_chk++; if (busy !== 1'b0 || underrun !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ctrl: got busy=%b underrun=%b in_ready=%b expected 0 0 1", busy, underrun, in_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        send(24'hFFFFFF, 24'hFFFFFF, w);
        send(24'h123456, 24'h654321, w);
        repeat (40) @(posedge clk);
        @(negedge clk);
        n_chk++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_prestate: got busy=%b in_ready=%b expected 1 0", busy, in_ready); end
        rst = 1'b1;
        #1;
        n_chk++; if (sclk !== 1'b0 || lrclk !== 1'b0 || sdata !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_midframe: got sclk=%b lrclk=%b sdata=%b busy=%b in_ready=%b expected 0 0 0 0 1",
                               sclk, lrclk, sdata, busy, in_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_chk++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_discard: got busy=%b in_ready=%b expected 0 1", busy, in_ready); end
        clear_stats();
    endtask

    task automatic test_single();
        int w, n, u0;
        clear_stats();
        u0 = ur_cnt;
        send(24'hA50F3C, 24'h800001, w);
        n_chk++; if (w !== 0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL single_accept: got wait=%0d in_ready=%b busy=%b expected 0 0 0", w, in_ready, busy); end
        @(posedge clk);
        #1;
        n_chk++; if (busy !== 1'b1 || sdata !== 1'b1 || lrclk !== 1'b0 || sclk !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_firstbit: got busy=%b sdata=%b lrclk=%b sclk=%b in_ready=%b expected 1 1 0 0 1",
                               busy, sdata, lrclk, sclk, in_ready); end
        wait_underrun(n);
        n_chk++; if (n !== 192) begin
            n_fail++; $display("FAIL single_frame_len: got %0d cycles expected 192", n); end
        n_chk++; if (busy !== 1'b0 || sclk !== 1'b0 || lrclk !== 1'b0 || sdata !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: got busy=%b sclk=%b lrclk=%b sdata=%b expected 0 0 0 0", busy, sclk, lrclk, sdata); end
        @(posedge clk);
        #1;
        n_chk++; if (underrun !== 1'b0) begin
            n_fail++; $display("FAIL single_pulse_width: got underrun=%b expected 0", underrun); end
        repeat (4) @(posedge clk);
        #1;
        n_chk++; if (ur_cnt - u0 !== 1 || rmin !== 4 || rmax !== 4 || lr_err !== 0) begin
            n_fail++; $display("FAIL single_stats: got underruns=%0d rise=%0d..%0d lrerr=%0d expected 1 4..4 0",
                               ur_cnt - u0, rmin, rmax, lr_err); end
        n_chk++; if (words.size() !== 2) begin
            n_fail++; $display("FAIL single_words: got %0d words expected 2", words.size()); end
        else begin
            n_chk++; if (words[0] !== {1'b0, 24'hA50F3C} || words[1] !== {1'b1, 24'h800001}) begin
                n_fail++; $display("FAIL single_data: got %h %h expected 0a50f3c 1800001", words[0], words[1]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] el[8];
        logic [23:0] er[8];
        int w, n, u0;
        el = '{24'h123456, 24'h800000, 24'hFFFFFF, 24'h555555, 24'h0F0F0F, 24'h000001, 24'hC0FFEE, 24'h13579B};
        er = '{24'hFEDCBA, 24'h7FFFFF, 24'h000000, 24'hAAAAAA, 24'hF0F0F0, 24'h800001, 24'hBADA55, 24'h2468AC};
        clear_stats();
        u0 = ur_cnt;
        for (int i = 0; i < 8; i++) send(el[i], er[i], w);
        n_chk++; if (ur_cnt - u0 !== 0) begin
            n_fail++; $display("FAIL b2b_no_underrun: got %0d pulses expected 0", ur_cnt - u0); end
        wait_underrun(n);
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (ur_cnt - u0 !== 1) begin
            n_fail++; $display("FAIL b2b_underrun_count: got %0d expected 1", ur_cnt - u0); end
        n_chk++; if (rmin !== 4 || rmax !== 4) begin
            n_fail++; $display("FAIL b2b_sclk_period: got %0d..%0d expected 4..4", rmin, rmax); end
        n_chk++; if (lmin !== 192 || lmax !== 192 || lr_err !== 0) begin
            n_fail++; $display("FAIL b2b_lrclk_period: got %0d..%0d lrerr=%0d expected 192..192 0", lmin, lmax, lr_err); end
        n_chk++; if (words.size() !== 16) begin
            n_fail++; $display("FAIL b2b_words: got %0d words expected 16", words.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                n_chk++;
                if (words[i] !== ((i % 2 == 0) ? {1'b0, el[i/2]} : {1'b1, er[i/2]})) begin
                    n_fail++; $display("FAIL b2b_word%0d: got %h expected %h", i, words[i],
                                       ((i % 2 == 0) ? {1'b0, el[i/2]} : {1'b1, er[i/2]})); end
            end
        end
    endtask

    task automatic test_late_feed();
        int w, n, u0;
        clear_stats();
        u0 = ur_cnt;
        send(24'h0000FF, 24'hFF0000, w);
        wait_underrun(n);
        send(24'h3C3C3C, 24'hC3C3C3, w);
        n_chk++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL late_gap: got busy=%b in_ready=%b expected 0 0", busy, in_ready); end
        wait_underrun(n);
        n_chk++; if (n !== 193) begin
            n_fail++; $display("FAIL late_frame2_len: got %0d expected 193", n); end
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (ur_cnt - u0 !== 2 || rmin !== 4 || rmax !== 6) begin
            n_fail++; $display("FAIL late_stats: got underruns=%0d rise=%0d..%0d expected 2 4..6", ur_cnt - u0, rmin, rmax); end
        n_chk++; if (words.size() !== 4) begin
            n_fail++; $display("FAIL late_words: got %0d words expected 4", words.size()); end
        else begin
            n_chk++; if (words[2] !== {1'b0, 24'h3C3C3C} || words[3] !== {1'b1, 24'hC3C3C3}) begin
                n_fail++; $display("FAIL late_data: got %h %h expected 03c3c3c 1c3c3c3", words[2], words[3]); end
        end
    endtask

    task automatic test_backpressure();
        int w1, w2, w3, w4, n;
        clear_stats();
        send(24'h111111, 24'h222222, w1);
        send(24'h333333, 24'h444444, w2);
        send(24'h555555, 24'h666666, w3);
        send(24'h777777, 24'h888888, w4);
        n_chk++; if (w1 !== 0 || w2 !== 1 || w3 !== 191 || w4 !== 191) begin
            n_fail++; $display("FAIL bp_ready_low: got waits %0d %0d %0d %0d expected 0 1 191 191", w1, w2, w3, w4); end
        wait_underrun(n);
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (words.size() !== 8) begin
            n_fail++; $display("FAIL bp_words: got %0d words expected 8", words.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_chk++;
                if (words[i] !== {1'(i % 2), {6{4'(i + 1)}}}) begin
                    n_fail++; $display("FAIL bp_word%0d: got %h expected %h", i, words[i], {1'(i % 2), {6{4'(i + 1)}}}); end
            end
        end
    endtask

    task automatic test_params();
        int n, u0;
        u0 = ur_cnt2;
        words2.delete();
        last_rise2 = -1; rmin2 = 999999; rmax2 = 0; lr_err2 = 0;
        send2(16'hC3A5, 16'h7E01);
        @(posedge clk);
        #1;
        n = 1;
        n_chk++; if (busy2 !== 1'b1 || sdata2 !== 1'b1 || lrclk2 !== 1'b0) begin
            n_fail++; $display("FAIL p16_firstbit: got busy=%b sdata=%b lrclk=%b expected 1 1 0", busy2, sdata2, lrclk2); end
        while (!underrun2 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_chk++; if (n !== 65) begin
            n_fail++; $display("FAIL p16_frame_len: got %0d expected 65", n); end
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (rmin2 !== 2 || rmax2 !== 2 || ur_cnt2 - u0 !== 1 || lr_err2 !== 0) begin
            n_fail++; $display("FAIL p16_stats: got rise=%0d..%0d underruns=%0d lrerr=%0d expected 2..2 1 0",
                               rmin2, rmax2, ur_cnt2 - u0, lr_err2); end
        n_chk++; if (words2.size() !== 2) begin
            n_fail++; $display("FAIL p16_words: got %0d expected 2", words2.size()); end
        else begin
            n_chk++; if (words2[0] !== {1'b0, 16'hC3A5} || words2[1] !== {1'b1, 16'h7E01}) begin
                n_fail++; $display("FAIL p16_data: got %h %h expected 0c3a5 17e01", words2[0], words2[1]); end
        end
    endtask

    initial begin
        in_left = '0; in_right = '0; in_left2 = '0; in_right2 = '0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_late_feed();
        test_backpressure();
        test_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
